// File: rtl/uart_result_tx_if.sv
// Handshake and serial-line bundle between the calculator datapath and the
// result transmitter.
interface uart_result_tx_if #(
    parameter int RES_W = 24
);
    logic             start;
    logic [RES_W-1:0] result;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             txd;

    modport master (output start, result, is_signed, input busy, done, txd);
    modport slave  (input start, result, is_signed, output busy, done, txd);
endinterface

// File: rtl/uart_result_tx.sv
// Serialises a result word on txd as ASCII hex: optional '-', NDIG digits
// (MS nibble first, leading zeros kept), CR, LF; 8N1, LSB first.
module uart_result_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int RES_W        = 24
) (
    input  logic              clk,
    input  logic              rst,
    uart_result_tx_if.slave   bus
);
    localparam int NDIG   = RES_W / 4;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = $clog2(NDIG + 3);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_CR    = IDX_W'(NDIG + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG + 2);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

    state_t            r_state, w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_shift;
    logic [RES_W-1:0]  r_mag;
    logic              r_txd, r_busy, r_done;

    logic              w_baud_end, w_last_char, w_txd_next, w_accept, w_neg;
    logic [RES_W-1:0]  w_mag_in;
    logic [7:0]        w_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_last_char = (r_idx == IDX_LAST);
    assign w_neg       = bus.is_signed & bus.result[RES_W-1];
    assign w_mag_in    = w_neg ? (~bus.result + RES_W'(1)) : bus.result;

    // Index 0 is the sign slot; unsigned/positive results start at index 1.
    always_comb begin
        w_char = 8'h0A;
        if (r_idx == '0)
            w_char = 8'h2D;
        else if (r_idx == IDX_CR)
            w_char = 8'h0D;
        else if (r_idx == IDX_LAST)
            w_char = 8'h0A;
        else
            w_char = hex_ascii(r_mag[RES_W-1 -: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every variable here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_txd_next   = 1'b1;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_state_next = S_LOAD;
            end
            S_LOAD:  w_state_next = S_START;
            S_START: begin
                w_txd_next = 1'b0;
                if (w_baud_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                w_txd_next = r_shift[0];
                if (w_baud_end && r_bit == 3'd7) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_baud_end) w_state_next = w_last_char ? S_IDLE : S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_mag   <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_txd  <= w_txd_next;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_accept) begin
                        r_mag  <= w_mag_in;
                        r_idx  <= w_neg ? IDX_W'(0) : IDX_W'(1);
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_shift <= w_char;
                    r_baud  <= '0;
                    if (r_idx >= IDX_W'(1) && r_idx <= IDX_W'(NDIG))
                        r_mag <= r_mag << 4;
                end
                S_START: r_baud <= w_baud_end ? '0 : r_baud + BAUD_W'(1);
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_last_char) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: r_baud <= '0;
            endcase
        end
    end

    assign bus.txd  = r_txd;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: stimulus queues expected characters, a 16x
// mid-bit UART decoder pops and compares every received byte.
module tb_uart_result_tx;
    localparam int CPB   = 16;
    localparam int RES_W = 24;
    localparam int CHAR_CYC = 1 + 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] exp_q[$];

    uart_result_tx_if #(.RES_W(RES_W)) bus ();

    uart_result_tx #(.CLKS_PER_BIT(CPB), .RES_W(RES_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n negedges, flagging a frame abort if reset is seen.
    task automatic step(input int n, inout logic aborted);
        repeat (n) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
        end
    endtask

    initial begin : monitor
        logic [7:0] rx_byte;
        logic       aborted;
        logic       frame_ok;
        forever begin
            @(negedge clk);
            if (bus.txd === 1'b0 && !rst) begin
                aborted  = 1'b0;
                frame_ok = 1'b1;
                step(CPB / 2, aborted);
                if (bus.txd !== 1'b0) frame_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    step(CPB, aborted);
                    rx_byte[i] = bus.txd;
                end
                step(CPB, aborted);
                if (bus.txd !== 1'b1) frame_ok = 1'b0;
                if (!aborted) begin
                    check("rx_framing", {31'd0, frame_ok}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_byte);
                    end else begin
                        check("rx_char", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [RES_W-1:0] res, input logic sgn, input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
        bus.start     = 1'b1;
        bus.result    = res;
        bus.is_signed = sgn;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.result    = ~res;
        bus.is_signed = ~sgn;
    endtask

    task automatic wait_fall(input string name);
        int cyc = 0;
        while (bus.txd !== 1'b0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(name, cyc, 2);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input string name, input int exp_cyc);
        int   cyc = 0;
        logic busy_ok = 1'b1;
        while (bus.done !== 1'b1 && cyc < 5000) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({name, "_cycles"}, cyc, exp_cyc);
        check({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic finish_tx(input string name, input int exp_cyc);
        wait_done(name, exp_cyc);
        @(negedge clk);
        check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin : stimulus
        int pulses;
        bus.start     = 1'b0;
        bus.result    = '0;
        bus.is_signed = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txd", {31'd0, bus.txd}, 32'd1);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(24'h000024, 1'b0, "000024\r\n");
        check("unsigned_busy_next", {31'd0, bus.busy}, 32'd1);
        wait_fall("unsigned_first_fall");
        finish_tx("unsigned", 8 * CHAR_CYC - 2);

        issue(24'hFFFFF6, 1'b1, "-00000a\r\n");
        finish_tx("signed_neg", 9 * CHAR_CYC);

        issue(24'h800000, 1'b1, "-800000\r\n");
        finish_tx("signed_min", 9 * CHAR_CYC);

        issue(24'h7FFFEA, 1'b1, "7fffea\r\n");
        finish_tx("signed_pos", 8 * CHAR_CYC);

        issue(24'hFFFFEA, 1'b0, "ffffea\r\n");
        wait_done("unsigned_letters", 8 * CHAR_CYC);
        issue(24'h00000a, 1'b0, "00000a\r\n");
        wait_fall("b2b_first_fall");
        finish_tx("b2b", 8 * CHAR_CYC - 2);

        issue(24'h0000ff, 1'b0, "0000ff\r\n");
        repeat (3 * CHAR_CYC + 20) @(negedge clk);
        bus.start  = 1'b1;
        bus.result = 24'h111111;
        @(negedge clk);
        bus.start  = 1'b0;
        finish_tx("busy_ignore", 8 * CHAR_CYC - (3 * CHAR_CYC + 21));
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("busy_ignore_extra_done", pulses, 0);
        check("busy_ignore_no_extra_chars", exp_q.size(), 0);

        issue(24'h123456, 1'b0, "123456\r\n");
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_txd", {31'd0, bus.txd}, 32'd1);
        check("midreset_busy", {31'd0, bus.busy}, 32'd0);
        check("midreset_done", {31'd0, bus.done}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check("midreset_no_done", pulses, 0);
        issue(24'h000001, 1'b0, "000001\r\n");
        finish_tx("after_reset", 8 * CHAR_CYC);

        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
